sprite_line_scheduler: RTL

Per-scanline sprite scheduler for the VGA sprite pipeline. It scans the sprite descriptor bank once per line and keeps up to MAX_PER_LINE sprites that intersect the next scanline in a double-buffered slot list. During the displayed line it arbitrates the single sprite line counter/memory port between the scheduled sprites, driving `sprite_on`, `sprite_datas` and a per-row memory base address. Only one sprite is presented at a time; the lowest slot wins.

---
 rtl/sprite_line_scheduler_if.sv | 34 +++
 rtl/sprite_line_scheduler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sprite_line_scheduler_if.sv
// sprite_line_scheduler_if
//   Bus between the sprite line scheduler and the rest of the sprite pipeline:
//   the descriptor bank read port and the per-pixel sprite selection outputs.
//   master : scheduler side (drives desc_addr and the sprite_* / line_base outputs)
//   slave  : descriptor bank / pixel pipeline side
//   desc_addr    descriptor read address
//   desc_data    descriptor read data, valid one cycle after desc_addr
//   sprite_on    a scheduled sprite covers the previous cycle's pixel_x
//   sprite_datas descriptor of the winning sprite
//   sprite_index bank index of the winning sprite
//   line_base    sprite memory base address of the current row
interface sprite_line_scheduler_if #(
    parameter int IDX_W  = 5,
    parameter int ADDR_W = 17
);
    logic [IDX_W-1:0]  desc_addr;
    logic [31:0]       desc_data;
    logic              sprite_on;
    logic [31:0]       sprite_datas;
    logic [IDX_W-1:0]  sprite_index;
    logic [ADDR_W-1:0] line_base;

    modport master (
        output desc_addr,
        input  desc_data,
        output sprite_on, sprite_datas, sprite_index, line_base
    );

    modport slave (
        input  desc_addr,
        output desc_data,
        input  sprite_on, sprite_datas, sprite_index, line_base
    );
endinterface

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler
//   Scans the descriptor bank once per line (started by line_start) and keeps
//   up to MAX_PER_LINE sprites that intersect the next line in a back buffer.
//   line_start swaps the back buffer to the front; during display the lowest
//   front slot covering pixel_x drives the registered sprite outputs.
// Ports:
//   clk_pixel, reset   clock, synchronous active-high reset
//   pixel_x, pixel_y   current raster position
//   line_start         one-cycle pulse at the start of horizontal blanking
//   bus                descriptor read port and sprite outputs (master side)
//   scan_busy          scan in progress
//   line_overflow      more than MAX_PER_LINE hits on the displayed line
//   scan_overrun       pulse: line_start arrived while a scan was running
module sprite_line_scheduler #(
    parameter int N_SPRITES    = 32,
    parameter int MAX_PER_LINE = 4,
    parameter int SPRITE_W     = 20,
    parameter int SPRITE_H     = 20,
    parameter int V_LINES      = 480,
    parameter int size_x       = 10,
    parameter int size_y       = 9,
    parameter int size_address = 17
) (
    input  logic                clk_pixel,
    input  logic                reset,
    input  logic [size_x-1:0]   pixel_x,
    input  logic [size_y-1:0]   pixel_y,
    input  logic                line_start,
    sprite_line_scheduler_if.master bus,
    output logic                scan_busy,
    output logic                line_overflow,
    output logic                scan_overrun
);
    localparam int IDX_W  = $clog2(N_SPRITES);
    localparam int CNT_W  = $clog2(MAX_PER_LINE + 1);
    localparam int SLOT_W = $clog2(MAX_PER_LINE);
    localparam int XW     = size_x + 1;
    localparam int YW     = size_y + 1;

    typedef enum logic [1:0] {IDLE, SCAN, LAST} state_t;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [31:0]       desc;
        logic [size_y-1:0] row;
    } slot_t;

    state_t                  state;
    slot_t                   front [MAX_PER_LINE];
    slot_t                   back  [MAX_PER_LINE];
    logic [MAX_PER_LINE-1:0] front_vld;
    logic [CNT_W-1:0]        back_cnt;
    logic                    back_ovf;
    logic [size_y-1:0]       tl;

    // ---------------- scan evaluation ----------------
    // desc_data lags desc_addr by one cycle, so in SCAN the data belongs to
    // desc_addr-1 (nothing valid yet while desc_addr is still 0); LAST holds
    // desc_addr at the final index so its data is that index.
    logic [YW-1:0]     tl_w, y_w, y_end;
    logic              eval, scan_hit;
    logic [IDX_W-1:0]  eval_idx;
    logic [size_y-1:0] tl_next;

    assign tl_w     = {1'b0, tl};
    assign y_w      = {1'b0, bus.desc_data[17:9]};
    assign y_end    = y_w + YW'(SPRITE_H - 1);
    assign scan_hit = bus.desc_data[29] && (tl_w >= y_w) && (tl_w <= y_end);
    assign eval     = ((state == SCAN) && (bus.desc_addr != '0)) || (state == LAST);
    assign eval_idx = (state == LAST) ? bus.desc_addr : bus.desc_addr - 1'b1;
    assign tl_next  = (pixel_y == size_y'(V_LINES - 1)) ? '0 : pixel_y + 1'b1;

    // ---------------- display arbitration ----------------
    logic [MAX_PER_LINE-1:0] x_hit;
    logic [XW-1:0]           px_w;
    logic                    disp_hit;
    logic [SLOT_W-1:0]       disp_sel;
    slot_t                   win;

    assign px_w = {1'b0, pixel_x};

    for (genvar g = 0; g < MAX_PER_LINE; g++) begin : g_xcmp
        logic [XW-1:0] xs;
        assign xs       = XW'(front[g].desc[26:18]);
        assign x_hit[g] = front_vld[g] && (px_w >= xs) && (px_w <= xs + XW'(SPRITE_W - 1));
    end

    // Descending walk so the lowest matching slot is the last assignment.
    always_comb begin
        disp_hit = 1'b0;
        disp_sel = '0;
        for (int i = MAX_PER_LINE - 1; i >= 0; i--) begin
            if (x_hit[i]) begin
                disp_hit = 1'b1;
                disp_sel = SLOT_W'(i);
            end
        end
    end

    assign win = front[disp_sel];

    // ---------------- state ----------------
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state             <= IDLE;
            bus.desc_addr     <= '0;
            front_vld         <= '0;
            back_cnt          <= '0;
            back_ovf          <= 1'b0;
            tl                <= '0;
            scan_busy         <= 1'b0;
            line_overflow     <= 1'b0;
            scan_overrun      <= 1'b0;
            bus.sprite_on     <= 1'b0;
            bus.sprite_datas  <= '0;
            bus.sprite_index  <= '0;
            bus.line_base     <= '0;
        end else begin
            scan_overrun <= 1'b0;

            if (line_start) begin
                // Swap: a partial back buffer (overrun) goes in as-is.
                for (int i = 0; i < MAX_PER_LINE; i++) begin
                    front[i]     <= back[i];
                    front_vld[i] <= (CNT_W'(i) < back_cnt);
                end
                line_overflow <= back_ovf;
                back_cnt      <= '0;
                back_ovf      <= 1'b0;
                tl            <= tl_next;
                bus.desc_addr <= '0;
                state         <= SCAN;
                scan_busy     <= 1'b1;
                scan_overrun  <= (state != IDLE);
            end else begin
                if (eval && scan_hit) begin
                    if (back_cnt < CNT_W'(MAX_PER_LINE)) begin
                        back[back_cnt[SLOT_W-1:0]] <= '{idx:  eval_idx,
                                                        desc: bus.desc_data,
                                                        row:  tl - bus.desc_data[17:9]};
                        back_cnt <= back_cnt + 1'b1;
                    end else begin
                        back_ovf <= 1'b1;
                    end
                end

                case (state)
                    SCAN: begin
                        if (bus.desc_addr == IDX_W'(N_SPRITES - 1)) state <= LAST;
                        else bus.desc_addr <= bus.desc_addr + 1'b1;
                    end
                    LAST: begin
                        state     <= IDLE;
                        scan_busy <= 1'b0;
                    end
                    default: ;
                endcase
            end

            // Display outputs hold their last winner when nothing covers pixel_x.
            bus.sprite_on <= disp_hit;
            if (disp_hit) begin
                bus.sprite_datas <= win.desc;
                bus.sprite_index <= win.idx;
                bus.line_base    <= size_address'(win.desc[8:0])
                                  + size_address'(win.row) * size_address'(SPRITE_W);
            end
        end
    end
endmodule
